hazard_controller: RTL and testbench

//  Pipeline hazard controller for the 5-stage MIPS core. Sits beside the ID/EX forwarding

---
 rtl/hazard_controller.sv | 153 +++++++++++++++
 tb/tb_hazard_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage MIPS core: operand forwarding selects, load-use and HI/LO stalls,
// branch flush, and a mult/div busy FSM. Define HAZARD_PERF_COUNTERS_EN to add stall/flush counters.

module hazard_fwd_unit (
  input  logic [4:0] src,
  input  logic       exmem_wr,
  input  logic [4:0] exmem_rd,
  input  logic       memwb_wr,
  input  logic [4:0] memwb_rd,
  output logic [1:0] sel
);
  always_comb begin
    sel = 2'b00;
    if (exmem_wr && exmem_rd != 5'd0 && exmem_rd == src)      sel = 2'b10;
    else if (memwb_wr && memwb_rd != 5'd0 && memwb_rd == src) sel = 2'b01;
  end
endmodule

module hazard_controller #(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 6
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] IFID_Instruction,
  input  logic [4:0]  IDEX_RegRS,
  input  logic [4:0]  IDEX_RegRT,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_RegD,
  input  logic        EXMEM_RegWrite,
  input  logic [4:0]  EXMEM_RegD,
  input  logic        MEMWB_RegWrite,
  input  logic [4:0]  MEMWB_RegD,
  input  logic        Branch_Taken,
  input  logic        MulDiv_Start,
  output logic [1:0]  Fwd_A_Sel,
  output logic [1:0]  Fwd_B_Sel,
  output logic        Stall_PC,
  output logic        Stall_IFID,
  output logic        Bubble_IDEX,
  output logic        Flush_IFID,
  output logic        MulDiv_Busy
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [31:0] Stall_Count,
  output logic [31:0] Flush_Count
`endif
);
  localparam int NUM_OPS = 2;

  typedef enum logic {ST_RUN, ST_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Operand 0 is ALU A (rs), operand 1 is ALU B (rt).
  logic [NUM_OPS-1:0][4:0] op_src;
  logic [NUM_OPS-1:0][1:0] fwd_sel;

  assign op_src = {IDEX_RegRT, IDEX_RegRS};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    hazard_fwd_unit u_fwd (
      .src      (op_src[g]),
      .exmem_wr (EXMEM_RegWrite),
      .exmem_rd (EXMEM_RegD),
      .memwb_wr (MEMWB_RegWrite),
      .memwb_rd (MEMWB_RegD),
      .sel      (fwd_sel[g])
    );
  end

  logic [5:0] id_opcode, id_funct;
  logic [4:0] id_rs, id_rt;
  logic       unused_instr_bits;
  logic       load_use, hilo_dep, stall, flush;

  assign id_opcode         = IFID_Instruction[31:26];
  assign id_rs             = IFID_Instruction[25:21];
  assign id_rt             = IFID_Instruction[20:16];
  assign id_funct          = IFID_Instruction[5:0];
  assign unused_instr_bits = ^IFID_Instruction[15:6];

  assign load_use = IDEX_MemRead && IDEX_RegD != 5'd0 &&
                    (IDEX_RegD == id_rs || IDEX_RegD == id_rt);
  assign hilo_dep = id_opcode == 6'd0 &&
                    id_funct inside {6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B};

  // Outputs are forced low while reset is asserted, independent of the clock.
  assign stall = RESET && (load_use || (state_q == ST_BUSY && hilo_dep));
  assign flush = RESET && Branch_Taken && !stall;

  assign Fwd_A_Sel   = RESET ? fwd_sel[0] : 2'b00;
  assign Fwd_B_Sel   = RESET ? fwd_sel[1] : 2'b00;
  assign Stall_PC    = stall;
  assign Stall_IFID  = stall;
  assign Bubble_IDEX = stall;
  assign Flush_IFID  = flush;
  assign MulDiv_Busy = (state_q == ST_BUSY);

  // BUSY lasts MULDIV_LAT-1 cycles; a start while busy cannot occur and is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (MulDiv_Start) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(MULDIV_LAT - 1);
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: driver queues expected outputs, monitor compares at negedge.
module tb_hazard_controller;
  localparam int LAT = 4;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] IFID_Instruction;
  logic [4:0]  IDEX_RegRS, IDEX_RegRT, IDEX_RegD, EXMEM_RegD, MEMWB_RegD;
  logic        IDEX_MemRead, EXMEM_RegWrite, MEMWB_RegWrite, Branch_Taken, MulDiv_Start;
  logic [1:0]  Fwd_A_Sel, Fwd_B_Sel;
  logic        Stall_PC, Stall_IFID, Bubble_IDEX, Flush_IFID, MulDiv_Busy;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] Stall_Count, Flush_Count;
`endif

  hazard_controller #(.MULDIV_LAT(LAT), .CNT_W(6)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .IFID_Instruction(IFID_Instruction),
    .IDEX_RegRS(IDEX_RegRS), .IDEX_RegRT(IDEX_RegRT), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_RegD(IDEX_RegD), .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_RegD(EXMEM_RegD),
    .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_RegD(MEMWB_RegD), .Branch_Taken(Branch_Taken),
    .MulDiv_Start(MulDiv_Start), .Fwd_A_Sel(Fwd_A_Sel), .Fwd_B_Sel(Fwd_B_Sel),
    .Stall_PC(Stall_PC), .Stall_IFID(Stall_IFID), .Bubble_IDEX(Bubble_IDEX),
    .Flush_IFID(Flush_IFID), .MulDiv_Busy(MulDiv_Busy)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    string      name;
    logic [8:0] outs; // {fwd_a, fwd_b, stall_pc, stall_ifid, bubble, flush, busy}
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADD_9_8_1 = {6'd0, 5'd8, 5'd1, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] I_ADD_3_4_5 = {6'd0, 5'd4, 5'd5, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] I_MFLO_2    = {6'd0, 5'd0, 5'd0, 5'd2, 5'd0, 6'h12};
  localparam logic [31:0] I_LW_RT8    = {6'h23, 5'd2, 5'd8, 16'd0};

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic clr();
    IFID_Instruction = 32'd0;
    IDEX_RegRS = 5'd0; IDEX_RegRT = 5'd0; IDEX_RegD = 5'd0; IDEX_MemRead = 1'b0;
    EXMEM_RegWrite = 1'b0; EXMEM_RegD = 5'd0; MEMWB_RegWrite = 1'b0; MEMWB_RegD = 5'd0;
    Branch_Taken = 1'b0; MulDiv_Start = 1'b0;
  endtask

  // st drives all three stall outputs together.
  task automatic expect_out(input string name, input logic [1:0] fa, input logic [1:0] fb,
                            input logic st, input logic fl, input logic bz);
    exp_t e;
    e.name = name;
    e.outs = {fa, fb, st, st, st, fl, bz};
    q.push_back(e);
  endtask

  always @(negedge CLOCK) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e = q.pop_front();
      act = {Fwd_A_Sel, Fwd_B_Sel, Stall_PC, Stall_IFID, Bubble_IDEX, Flush_IFID, MulDiv_Busy};
      checks++;
      if (act !== e.outs) begin
        errors++;
        $display("FAIL %s: got %b expected %b (fa,fb,spc,sif,bub,flush,busy)", e.name, act, e.outs);
      end
    end
  end

  initial begin
    RESET = 1'b0;
    clr();
    // Forwarding match present but reset holds every output low.
    tick(); EXMEM_RegWrite = 1'b1; EXMEM_RegD = 5'd5; IDEX_RegRS = 5'd5; IDEX_MemRead = 1'b1;
    IDEX_RegD = 5'd8; IFID_Instruction = I_ADD_9_8_1; Branch_Taken = 1'b1;
    expect_out("reset_low", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); RESET = 1'b1; clr();
    expect_out("idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_COUNTERS_EN
    checks++;
    if (Stall_Count !== 32'd0 || Flush_Count !== 32'd0) begin
      errors++;
      $display("FAIL cnt_after_reset: got %0d/%0d expected 0/0", Stall_Count, Flush_Count);
    end
`endif

    // Forwarding priority and encodings
    tick(); EXMEM_RegWrite = 1'b1; MEMWB_RegWrite = 1'b1;
    EXMEM_RegD = 5'd5; MEMWB_RegD = 5'd5; IDEX_RegRS = 5'd5;
    expect_out("fwd_exmem_wins", 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); EXMEM_RegWrite = 1'b0;
    expect_out("fwd_memwb", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); EXMEM_RegWrite = 1'b1; EXMEM_RegD = 5'd7; IDEX_RegRS = 5'd7; IDEX_RegRT = 5'd5;
    expect_out("fwd_a_ex_b_wb", 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
    tick(); EXMEM_RegD = 5'd0; MEMWB_RegD = 5'd0; IDEX_RegRS = 5'd0; IDEX_RegRT = 5'd0;
    expect_out("fwd_zero_reg", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Load-use: lw $8 in EX, add $9,$8,$1 in ID
    tick(); clr(); IDEX_MemRead = 1'b1; IDEX_RegD = 5'd8; IFID_Instruction = I_ADD_9_8_1;
    expect_out("loaduse_stall", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    tick(); clr(); EXMEM_RegWrite = 1'b1; EXMEM_RegD = 5'd8; IFID_Instruction = I_ADD_9_8_1;
    expect_out("loaduse_release", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); clr(); IDEX_RegRS = 5'd8; IDEX_RegRT = 5'd1; MEMWB_RegWrite = 1'b1; MEMWB_RegD = 5'd8;
    IFID_Instruction = I_ADD_3_4_5;
    expect_out("loaduse_fwd_wb", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); clr(); IDEX_MemRead = 1'b1; IDEX_RegD = 5'd8; IFID_Instruction = I_LW_RT8;
    expect_out("loaduse_rt", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    tick(); clr(); IDEX_MemRead = 1'b1; IDEX_RegD = 5'd0;
    expect_out("loaduse_zero", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Branch vs stall priority
    tick(); clr(); IDEX_MemRead = 1'b1; IDEX_RegD = 5'd8; IFID_Instruction = I_ADD_9_8_1;
    Branch_Taken = 1'b1;
    expect_out("branch_blocked", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    tick(); clr(); Branch_Taken = 1'b1; IFID_Instruction = I_ADD_9_8_1;
    expect_out("branch_flush", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);

    // Mult/div busy with dependent mflo: 3 busy/stall cycles for LAT=4
    tick(); clr(); MulDiv_Start = 1'b1; IFID_Instruction = I_ADD_3_4_5;
    expect_out("md_issue", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LAT - 1; i++) begin
      tick(); clr(); IFID_Instruction = I_MFLO_2;
      expect_out($sformatf("md_busy_stall%0d", i), 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    end
    tick(); clr(); IFID_Instruction = I_MFLO_2;
    expect_out("md_release", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Independent instruction during BUSY flows freely
    tick(); clr(); MulDiv_Start = 1'b1;
    expect_out("md_issue2", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); clr(); IFID_Instruction = I_ADD_3_4_5; Branch_Taken = 1'b1;
    expect_out("md_busy_indep", 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    tick(); clr(); IFID_Instruction = I_MFLO_2;
    expect_out("md_busy_dep", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);

    // Async reset mid-BUSY, between clock edges
    tick(); clr(); IFID_Instruction = I_MFLO_2; EXMEM_RegWrite = 1'b1; EXMEM_RegD = 5'd4;
    IDEX_RegRS = 5'd4; RESET = 1'b0;
    expect_out("reset_mid_busy", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); RESET = 1'b1; clr(); IFID_Instruction = I_MFLO_2;
    expect_out("after_reset_run", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

`ifdef HAZARD_PERF_COUNTERS_EN
    tick(); clr(); IDEX_MemRead = 1'b1; IDEX_RegD = 5'd8; IFID_Instruction = I_ADD_9_8_1;
    expect_out("cnt_stall_cycle", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    tick(); clr(); Branch_Taken = 1'b1;
    expect_out("cnt_flush_cycle", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    tick(); clr();
    checks++;
    if (Stall_Count !== 32'd1 || Flush_Count !== 32'd1) begin
      errors++;
      $display("FAIL cnt_increment: got %0d/%0d expected 1/1", Stall_Count, Flush_Count);
    end
`endif

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge CLOCK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
